// File: rtl/sum_tx_sequencer.sv
// Two-operand adder with debounced pushbuttons; on a send press the sum is sent to a UART as ASCII digits.
// Optional macro SUM_TX_CRLF_EN appends CR LF to the message (4 bytes instead of 2).

module sum_tx_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          w_flip;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it.
  assign w_flip  = (r_sync[1] != r_level) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign o_press = w_flip && r_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b11;
      r_level <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module sum_tx_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       save_a_n,
  input  logic       save_b_n,
  input  logic       send_n,
  input  logic [3:0] data_input,
  input  logic       tx_busy,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [4:0] sum,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       busy
);
  localparam int NBTN = 3;
`ifdef SUM_TX_CRLF_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd1;
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } state_t;

  logic [NBTN-1:0] w_btn_n;
  logic [NBTN-1:0] w_press;

  assign w_btn_n = {send_n, save_b_n, save_a_n};

  generate
    for (genvar g = 0; g < NBTN; g++) begin : g_btn
      sum_tx_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk     (clk),
        .reset_n (reset_n),
        .i_btn_n (w_btn_n[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  logic [3:0] r_a, r_b;
  logic [4:0] r_sum;

  // Operand loads are independent of the FSM so saves work mid-transmission.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
    end else begin
      if (w_press[0]) r_a <= data_input;
      if (w_press[1]) r_b <= data_input;
      r_sum <= {1'b0, r_a} + {1'b0, r_b};
    end
  end

  state_t     r_state, w_state_nxt;
  logic [1:0] r_idx, w_idx_nxt;
  logic [4:0] r_snap, w_snap_nxt;
  logic [7:0] r_tx_data, w_tx_data_nxt;
  logic       r_tx_start, w_tx_start_nxt;
  logic [3:0] w_tens;
  logic [4:0] w_ones;
  logic [7:0] w_cur_byte;

  // Snapshot is at most 30, so the tens digit is a 3-way compare instead of a divider.
  always_comb begin
    w_tens = 4'd0;
    if (r_snap >= 5'd30)      w_tens = 4'd3;
    else if (r_snap >= 5'd20) w_tens = 4'd2;
    else if (r_snap >= 5'd10) w_tens = 4'd1;
    w_ones = r_snap - (5'(w_tens) * 5'd10);
  end

  always_comb begin
    w_cur_byte = 8'h30 + {4'h0, w_tens};
    case (r_idx)
      2'd0:    w_cur_byte = 8'h30 + {4'h0, w_tens};
      2'd1:    w_cur_byte = 8'h30 + {3'b000, w_ones};
      2'd2:    w_cur_byte = 8'h0D;
      default: w_cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_snap_nxt     = r_snap;
    w_tx_data_nxt  = r_tx_data;
    w_tx_start_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_press[2]) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_snap_nxt  = r_sum;
        w_idx_nxt   = 2'd0;
        w_state_nxt = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = w_cur_byte;
          w_state_nxt    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = IDLE;
          end else begin
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = SEND;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_snap     <= '0;
      r_tx_data  <= '0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_snap     <= w_snap_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_start <= w_tx_start_nxt;
    end
  end

  assign a        = r_a;
  assign b        = r_b;
  assign sum      = r_sum;
  assign tx_data  = r_tx_data;
  assign tx_start = r_tx_start;
  assign busy     = (r_state != IDLE);
endmodule

// File: tb/tb_sum_tx_sequencer.sv
// Directed bench for sum_tx_sequencer with a simple UART busy model and byte capture.
module tb_sum_tx_sequencer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       save_a_n = 1'b1, save_b_n = 1'b1, send_n = 1'b1;
  logic [3:0] data_input = '0;
  logic       tx_busy;
  logic [3:0] a, b;
  logic [4:0] sum;
  logic [7:0] tx_data;
  logic       tx_start, busy;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  logic [7:0] cap[$];

  always #5 clk = ~clk;

  sum_tx_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .send_n(send_n), .data_input(data_input), .tx_busy(tx_busy), .a(a), .b(b),
    .sum(sum), .tx_data(tx_data), .tx_start(tx_start), .busy(busy)
  );

  // UART model: busy for 20 cycles after each accepted start pulse.
  always @(posedge clk) begin
    if (tx_start) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) if (tx_start) cap.push_back(tx_data);

  typedef struct {
    logic [3:0] av;
    logic [3:0] bv;
    logic [4:0] s;
    logic [7:0] t;
    logic [7:0] o;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic press(input logic [2:0] mask, input logic [3:0] d, input int cyc);
    data_input = d;
    save_a_n = ~mask[0];
    save_b_n = ~mask[1];
    send_n   = ~mask[2];
    repeat (cyc) @(negedge clk);
    save_a_n = 1'b1;
    save_b_n = 1'b1;
    send_n   = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  function automatic int capb(input int i);
    return (cap.size() > i) ? int'(cap[i]) : 'hFFFF;
  endfunction

  task automatic chk_msg(input string nm, input logic [7:0] t, input logic [7:0] o);
    int nexp;
`ifdef SUM_TX_CRLF_EN
    nexp = 4;
`else
    nexp = 2;
`endif
    chk({nm, " count"}, cap.size(), nexp);
    chk({nm, " tens"}, capb(0), int'(t));
    chk({nm, " ones"}, capb(1), int'(o));
`ifdef SUM_TX_CRLF_EN
    chk({nm, " cr"}, capb(2), 'h0D);
    chk({nm, " lf"}, capb(3), 'h0A);
`endif
  endtask

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{av: 4'h7, bv: 4'h9, s: 5'd16, t: 8'h31, o: 8'h36};
    vecs[1] = '{av: 4'hF, bv: 4'hF, s: 5'd30, t: 8'h33, o: 8'h30};
    vecs[2] = '{av: 4'h0, bv: 4'h0, s: 5'd0,  t: 8'h30, o: 8'h30};
    vecs[3] = '{av: 4'h3, bv: 4'h4, s: 5'd7,  t: 8'h30, o: 8'h37};

    repeat (3) @(negedge clk);
    chk("rst a", a, 0);
    chk("rst b", b, 0);
    chk("rst sum", sum, 0);
    chk("rst tx_data", tx_data, 0);
    chk("rst tx_start", tx_start, 0);
    chk("rst busy", busy, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 3-cycle glitch is shorter than the debounce window.
    press(3'b001, 4'h5, 3);
    chk("glitch a", a, 0);
    chk("glitch sum", sum, 0);

    foreach (vecs[i]) begin
      press(3'b001, vecs[i].av, 10);
      press(3'b010, vecs[i].bv, 10);
      chk($sformatf("v%0d a", i), a, vecs[i].av);
      chk($sformatf("v%0d b", i), b, vecs[i].bv);
      chk($sformatf("v%0d sum", i), sum, vecs[i].s);
      cap.delete();
      press(3'b100, 4'h0, 10);
      chk($sformatf("v%0d busy", i), busy, 1);
      wait_idle($sformatf("v%0d idle", i));
      chk_msg($sformatf("v%0d msg", i), vecs[i].t, vecs[i].o);
    end

    // Simultaneous saves load both operands.
    press(3'b011, 4'hC, 10);
    chk("both a", a, 12);
    chk("both b", b, 12);
    chk("both sum", sum, 24);

    // Save and re-send during a transmission: operands update, message keeps the snapshot.
    press(3'b001, 4'h7, 10);
    press(3'b010, 4'h9, 10);
    cap.delete();
    press(3'b100, 4'h0, 10);
    press(3'b101, 4'h1, 10);
    chk("mid a", a, 1);
    chk("mid sum", sum, 10);
    chk("mid busy", busy, 1);
    wait_idle("mid idle");
    repeat (60) @(negedge clk);
    chk("mid still idle", busy, 0);
    chk_msg("mid msg", 8'h31, 8'h36);

    // Reset in WAIT_DONE of the first byte, with save_a held through reset.
    press(3'b001, 4'h7, 10);
    press(3'b010, 4'h9, 10);
    cap.delete();
    send_n = 1'b0;
    n = 0;
    while (cap.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst2 first byte", capb(0), 'h31);
    send_n = 1'b1;
    repeat (5) @(negedge clk);
    data_input = 4'h6;
    save_a_n = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rst2 a", a, 0);
    chk("rst2 b", b, 0);
    chk("rst2 tx_data", tx_data, 0);
    chk("rst2 tx_start", tx_start, 0);
    chk("rst2 busy", busy, 0);
    @(negedge clk);
    chk("rst2 sum", sum, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("held no early event", a, 0);
    repeat (12) @(negedge clk);
    chk("held a", a, 6);
    chk("held b", b, 0);
    chk("held sum", sum, 6);
    save_a_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("rst2 bytes", cap.size(), 1);
    chk("rst2 idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
